ysyx_lsu: RTL
=============

# ysyx_lsu

Parametrised, multi-cycle load/store unit that replaces the single-cycle, direct-call data-memory access inside the execute stage. It accepts one memory operation at a time from the EXU over a valid/ready handshake and issues it to the data-memory bus as a lane-aligned request with byte mask. It waits for the memory response, then returns sign- or zero-extended load data, or a store acknowledgement, over a second valid/ready handshake. Misaligned accesses are detected and faulted without touching memory.

## Interface
Parameters:
- XLEN, 32, data width; 32 or 64.
- ADDR_W, 32, address width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  EXU presents an operation.
- in_ready  out  1  LSU can accept; high only in IDLE.
- in_we  in  1  1 = store, 0 = load.
- in_size  in  2  00 byte, 01 half, 10 word, 11 double (legal only when XLEN=64).
- in_unsigned  in  1  loads only: zero-extend when 1, sign-extend when 0.
- in_addr  in  ADDR_W  byte address (ALU result).
- in_wdata  in  XLEN  store data, in the low bytes.
- out_valid  out  1  result available.
- out_ready  in  1  EXU/WBU consumes result.
- out_rdata  out  XLEN  extended load data; 0 for stores and faults.
- out_fault  out  1  misaligned or illegal-size access.
- mem_req_valid  out  1  bus request.
- mem_req_ready  in  1  bus accepts request.
- mem_req_we  out  1  write request.
- mem_req_addr  out  ADDR_W  in_addr with low log2(XLEN/8) bits cleared.
- mem_req_wdata  out  XLEN  store data shifted to its byte lane.
- mem_req_wmask  out  XLEN/8  byte enables; all zero for reads.
- mem_rsp_valid  in  1  read data returned or write acknowledged (single-cycle pulse).
- mem_rsp_rdata  in  XLEN  full-lane read data.

## Operation
- FSM states: IDLE, REQ, WAIT, RESP.
  - IDLE: in_ready=1. On in_valid, capture we/size/unsigned/addr/wdata.
    - Fault → RESP.
    - Otherwise → REQ.
  - REQ: mem_req_valid=1; request fields are stable while valid. On mem_req_ready → WAIT.
  - WAIT: on mem_rsp_valid, register the result → RESP.
  - RESP: out_valid=1, with out_rdata and out_fault stable. On out_ready → IDLE.
- Fault detection:
  - offset = addr mod XLEN/8.
  - Fault when size=01 and offset[0]≠0; size=10 and offset[1:0]≠0; size=11 and (XLEN=32 or offset[2:0]≠0).
  - A faulting operation issues no bus request; out_rdata=0 and out_fault=1.
- Store lanes:
  - mem_req_wdata = in_wdata << (8·offset).
  - mem_req_wmask = ((1<<2^size)−1) << offset.
  - Example (XLEN=32): byte at offset 2 gives mask 0100.
- Load extraction:
  - lane = mem_rsp_rdata >> (8·offset), truncated to 2^size bytes.
  - Sign- or zero-extended to XLEN per in_unsigned; the size that equals XLEN ignores in_unsigned.
- Stores complete on mem_rsp_valid (write ack) with out_rdata=0 and out_fault=0.
- mem_rsp_valid in IDLE, REQ or RESP is ignored.
- One outstanding operation only; no pipelining.

## Timing
- Reset values (asynchronous, during rst and after release):
  - state=IDLE, in_ready=1.
  - out_valid=0, out_rdata=0, out_fault=0.
  - mem_req_valid=0, mem_req_we=0, mem_req_addr=0, mem_req_wdata=0, mem_req_wmask=0.
- All outputs are registered or decoded from state; there is no combinational path from in_* or mem_rsp_* to out_*.
- Fastest non-fault sequence:
  - cycle 0: accept.
  - cycle 1: mem_req_valid; mem_req_ready also high.
  - cycle 2: mem_rsp_valid.
  - cycle 3: out_valid.
  - Latency 3 cycles plus bus stall cycles.
- Fault sequence: accept in cycle 0, out_valid in cycle 1.
- Back-to-back: out_ready in cycle n returns to IDLE, so in_ready=1 in cycle n+1.
- Reset asserted mid-operation abandons the transaction immediately; a late mem_rsp_valid after reset is ignored.

## Test plan
- LB, XLEN=32, addr=0x80000003, mem_rsp_rdata=0x80FF0011 → mem_req_addr=0x80000000, wmask=0000, out_rdata=0xFFFFFF80, out_fault=0, out_valid in cycle 3.
- LHU, addr=0x80000002, rdata=0xBEEF1234 → out_rdata=0x0000BEEF; the same access as LH → 0xFFFFBEEF.
- SB, addr=0x80000001, wdata=0x000000AB → mem_req_wdata=0x0000AB00, wmask=0010, mem_req_we=1; after ack, out_valid=1 with out_rdata=0.
- LW, addr=0x80000002 → out_fault=1 at cycle 1, mem_req_valid never asserted; size=11 with XLEN=32 also faults.
- Stalls:
  - mem_req_ready low for 4 cycles → request fields are held constant.
  - out_ready low for 3 cycles → out_valid and out_rdata are held.
  - in_valid held high throughout → next op accepted only in the cycle after out_ready.
- Assert rst while in WAIT, then pulse mem_rsp_valid → all outputs return to reset values, out_valid stays 0, and in_ready=1.

Source files
------------

// File: rtl/ysyx_lsu.sv
// ysyx_lsu: multi-cycle load/store unit between the EXU and the data-memory bus.
// Accepts one operation at a time, issues a lane-aligned bus request with a
// byte mask, waits for the response and returns extended load data or a store
// acknowledgement. Misaligned / illegal-size accesses fault without a bus request.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   in_valid/in_ready         EXU operation handshake (ready only in IDLE)
//   in_we, in_size,
//   in_unsigned, in_addr,
//   in_wdata                  operation fields, captured on acceptance
//   out_valid/out_ready       result handshake
//   out_rdata, out_fault      extended load data (0 for stores/faults), fault flag
//   mem_req_*                 bus request: valid/ready, we, aligned addr, lane data, byte mask
//   mem_rsp_valid/rdata       bus response pulse and full-lane read data
//
// state  | meaning
// IDLE   | ready for a new operation
// REQ    | bus request presented, waiting for mem_req_ready
// WAIT   | request accepted, waiting for mem_rsp_valid
// RESP   | result presented, waiting for out_ready
module ysyx_lsu #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_we,
  input  logic [1:0]        in_size,
  input  logic              in_unsigned,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [XLEN-1:0]   in_wdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_rdata,
  output logic              out_fault,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_we,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [XLEN-1:0]   mem_req_wdata,
  output logic [XLEN/8-1:0] mem_req_wmask,
  input  logic              mem_rsp_valid,
  input  logic [XLEN-1:0]   mem_rsp_rdata
);

  localparam int NB    = XLEN / 8;
  localparam int OFF_W = $clog2(NB);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

  state_t            r_state;
  logic              r_we;
  logic [1:0]        r_size;
  logic              r_unsigned;
  logic [OFF_W-1:0]  r_off;
  logic [ADDR_W-1:0] r_addr;
  logic [XLEN-1:0]   r_wdata;
  logic [NB-1:0]     r_wmask;
  logic [XLEN-1:0]   r_rdata;
  logic              r_fault;

  logic [OFF_W-1:0]  w_off;
  logic              w_fault;
  logic [15:0]       w_bmask;
  logic [NB-1:0]     w_wmask;
  logic [XLEN-1:0]   w_wdata;
  logic [ADDR_W-1:0] w_aligned;
  logic [XLEN-1:0]   w_lane;
  logic [XLEN-1:0]   w_lmask;
  logic              w_sign;
  logic [XLEN-1:0]   w_load;

  assign w_off     = in_addr[OFF_W-1:0];
  assign w_aligned = {in_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign w_wdata   = in_wdata << {w_off, 3'b000};

  always_comb begin
    w_fault = 1'b0;
    w_bmask = 16'h0001;
    unique case (in_size)
      2'b00: begin w_fault = 1'b0;                              w_bmask = 16'h0001; end
      2'b01: begin w_fault = in_addr[0];                        w_bmask = 16'h0003; end
      2'b10: begin w_fault = |in_addr[1:0];                     w_bmask = 16'h000F; end
      2'b11: begin w_fault = (XLEN == 32) || (|in_addr[2:0]);   w_bmask = 16'h00FF; end
      default: ;
    endcase
  end

  // Reads never enable byte lanes.
  assign w_wmask = in_we ? NB'(w_bmask << w_off) : '0;

  // Load extraction: shift the addressed lane down, keep 2^size bytes and
  // fill the upper bits with the lane's top bit unless zero-extending.
  assign w_lane = mem_rsp_rdata >> {r_off, 3'b000};

  always_comb begin
    w_lmask = '1;
    w_sign  = w_lane[XLEN-1];
    unique case (r_size)
      2'b00: begin w_lmask = XLEN'(8'hFF);         w_sign = w_lane[7];      end
      2'b01: begin w_lmask = XLEN'(16'hFFFF);      w_sign = w_lane[15];     end
      2'b10: begin w_lmask = XLEN'(32'hFFFF_FFFF); w_sign = w_lane[31];     end
      2'b11: begin w_lmask = '1;                   w_sign = w_lane[XLEN-1]; end
      default: ;
    endcase
  end

  assign w_load = (w_lane & w_lmask) | ((w_sign && !r_unsigned) ? ~w_lmask : '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_we       <= 1'b0;
      r_size     <= 2'b00;
      r_unsigned <= 1'b0;
      r_off      <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_wmask    <= '0;
      r_rdata    <= '0;
      r_fault    <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_we       <= in_we;
            r_size     <= in_size;
            r_unsigned <= in_unsigned;
            r_off      <= w_off;
            r_addr     <= w_aligned;
            r_wdata    <= w_wdata;
            r_wmask    <= w_wmask;
            if (w_fault) begin
              r_rdata <= '0;
              r_fault <= 1'b1;
              r_state <= S_RESP;
            end else begin
              r_fault <= 1'b0;
              r_state <= S_REQ;
            end
          end
        end
        S_REQ: begin
          if (mem_req_ready) r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (mem_rsp_valid) begin
            r_rdata <= r_we ? '0 : w_load;
            r_fault <= 1'b0;
            r_state <= S_RESP;
          end
        end
        S_RESP: begin
          if (out_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready      = (r_state == S_IDLE);
  assign mem_req_valid = (r_state == S_REQ);
  assign out_valid     = (r_state == S_RESP);
  assign out_rdata     = r_rdata;
  assign out_fault     = r_fault;
  assign mem_req_we    = r_we;
  assign mem_req_addr  = r_addr;
  assign mem_req_wdata = r_wdata;
  assign mem_req_wmask = r_wmask;

endmodule
